mux_stream_n: RTL and testbench

//  Registered, handshaked N:1 selector for W-bit words; successor to the combinational wide muxes.

---
 rtl/mux_stream_pkg.sv | 15 +
 rtl/mux_stream_n_rr_picker.sv | 28 ++
 rtl/mux_stream_n.sv | 117 +++++++++++
 tb/tb_mux_stream_n.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux_stream_pkg.sv
// Shared types for the handshaked N:1 stream selector.
// Grant mode and output-register state encodings.
package mux_stream_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_t;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/mux_stream_n_rr_picker.sv
// Rotating-priority picker: first set req bit at or after ptr, wrapping.
// Ports: req[N], ptr[SW] in; gnt_valid, gnt_idx[SW] out (combinational).
module rr_picker #(
  parameter  int N  = 16,
  localparam int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic          gnt_valid,
  output logic [SW-1:0] gnt_idx
);

  // Scan from the far end back toward ptr so the closest hit wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SW'(idx);
      end
    end
  end

endmodule

// File: rtl/mux_stream_n.sv
// Registered, handshaked N:1 word selector with a 1-deep output register.
// Ports: clk, rst (sync, high); a[N*W], a_valid[N] -> a_ready[N] (one-hot);
// sel[SW], mode (fixed/round-robin); y[W], y_valid, y_src[SW] <- y_ready.
// Build option MUX_STREAM_RR_EN adds the round-robin picker and pointer;
// without it the mode input is ignored and selection is always fixed.
module mux_stream_n
  import mux_stream_pkg::*;
#(
  parameter  int N  = 16,
  parameter  int W  = 32,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] a,
  input  logic [N-1:0]   a_valid,
  output logic [N-1:0]   a_ready,
  input  logic [SW-1:0]  sel,
  input  logic           mode,
  output logic [W-1:0]   y,
  output logic           y_valid,
  input  logic           y_ready,
  output logic [SW-1:0]  y_src
);

  state_t        state_q, state_d;
  logic [W-1:0]  y_q, y_d;
  logic [SW-1:0] src_q, src_d;

  logic          gnt_found;
  logic [SW-1:0] gnt_idx;
  logic          load;

  // Fixed select; out-of-range sel (non power-of-2 N) never grants.
  logic          fx_found;
  assign fx_found = (int'(sel) < N) && a_valid[sel];

`ifdef MUX_STREAM_RR_EN
  logic [SW-1:0] ptr_q, ptr_d;
  logic          rr_found;
  logic [SW-1:0] rr_idx;
  logic          rr_mode;

  rr_picker #(.N(N)) u_pick (
    .req       (a_valid),
    .ptr       (ptr_q),
    .gnt_valid (rr_found),
    .gnt_idx   (rr_idx)
  );

  assign rr_mode   = (mode_t'(mode) == MODE_RR);
  assign gnt_found = rr_mode ? rr_found : fx_found;
  assign gnt_idx   = rr_mode ? rr_idx : sel;

  // Pointer moves just past the winner, only on an accepted RR word.
  always_comb begin
    ptr_d = ptr_q;
    if (load && rr_mode) begin
      ptr_d = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign gnt_found   = fx_found;
  assign gnt_idx     = sel;
`endif

  // Reset gates the handshake so no word is taken during reset.
  assign load = !rst && gnt_found &&
                ((state_q == S_EMPTY) || y_ready);

  always_comb begin
    a_ready = '0;
    if (load) a_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_EMPTY: if (load) state_d = S_FULL;
      S_FULL:  if (y_ready && !load) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
  end

  always_comb begin
    y_d   = y_q;
    src_d = src_q;
    if (load) begin
      y_d   = a[gnt_idx*W +: W];
      src_d = gnt_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      y_q     <= '0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      src_q   <= src_d;
    end
  end

  assign y       = y_q;
  assign y_src   = src_q;
  assign y_valid = (state_q == S_FULL);

endmodule

// File: tb/tb_mux_stream_n.sv
// Self-checking bench for mux_stream_n: directed cases plus random traffic
// against a cycle-level behavioural model of the selector.
module tb_mux_stream_n;

  localparam int N  = 16;
  localparam int W  = 32;
  localparam int SW = 4;

`ifdef MUX_STREAM_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] a;
  logic [N-1:0]   a_valid;
  logic [N-1:0]   a_ready;
  logic [SW-1:0]  sel;
  logic           mode;
  logic [W-1:0]   y;
  logic           y_valid;
  logic           y_ready;
  logic [SW-1:0]  y_src;

  mux_stream_n #(.N(N), .W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .sel     (sel),
    .mode    (mode),
    .y       (y),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .y_src   (y_src)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Behavioural model: one output slot plus the round-robin pointer.
  bit           m_full = 1'b0;
  logic [W-1:0] m_y    = '0;
  int           m_src  = 0;
  int           m_ptr  = 0;

  function automatic int m_grant();
    int i;
    if (rst) return -1;
    if (RR && mode) begin
      for (int k = 0; k < N; k++) begin
        i = (m_ptr + k) % N;
        if (a_valid[i]) return i;
      end
      return -1;
    end
    if (int'(sel) < N && a_valid[sel]) return int'(sel);
    return -1;
  endfunction

  always @(posedge clk) begin
    int g;
    g = m_grant();
    if (rst) begin
      m_full = 1'b0;
      m_y    = '0;
      m_src  = 0;
      m_ptr  = 0;
    end else if (g >= 0 && (!m_full || y_ready)) begin
      m_full = 1'b1;
      m_y    = a[g*W +: W];
      m_src  = g;
      if (RR && mode) m_ptr = (g + 1) % N;
    end else if (y_ready) begin
      m_full = 1'b0;
    end
  end

  always @(negedge clk) begin
    int g;
    logic [N-1:0] er;
    if (chk_en) begin
      g  = m_grant();
      er = '0;
      if (g >= 0 && (!m_full || y_ready)) er[g] = 1'b1;
      chk("y_valid", 64'(y_valid), 64'(m_full));
      chk("y", 64'(y), 64'(m_y));
      chk("y_src", 64'(y_src), 64'(m_src));
      chk("a_ready", 64'(a_ready), 64'(er));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int seq [6];
    logic [N-1:0] one;
    seq = '{0, 1, 15, 0, 1, 15};

    rst     = 1'b1;
    a_valid = '1;
    sel     = '0;
    mode    = 1'b0;
    y_ready = 1'b1;
    for (int i = 0; i < N; i++) a[i*W +: W] = 32'hA000_0000 + i;

    // Reset held two cycles with every channel valid.
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_y_valid", 64'(y_valid), 64'd0);
    chk("rst_y", 64'(y), 64'd0);
    chk("rst_y_src", 64'(y_src), 64'd0);
    chk("rst_a_ready", 64'(a_ready), 64'd0);
    rst = 1'b0;

    // Fixed sweep, back-to-back.
    for (int s = 0; s < N; s++) begin
      sel = SW'(s);
      #1;
      one = '0;
      one[s] = 1'b1;
      chk("fx_a_ready", 64'(a_ready), 64'(one));
      tick();
      chk("fx_y", 64'(y), 64'(32'hA000_0000 + s));
      chk("fx_y_src", 64'(y_src), 64'(s));
    end

    // Backpressure while sel wanders.
    y_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      sel = SW'(j + 5);
      #1;
      chk("bp_a_ready", 64'(a_ready), 64'd0);
      tick();
      chk("bp_y", 64'(y), 64'h0000_0000_A000_000F);
      chk("bp_y_src", 64'(y_src), 64'd15);
    end
    sel     = 4'd3;
    y_ready = 1'b1;
    #1;
    chk("bp_rel_a_ready", 64'(a_ready), 64'h0008);
    tick();
    chk("bp_rel_y", 64'(y), 64'h0000_0000_A000_0003);

`ifdef MUX_STREAM_RR_EN
    // Round-robin wrap over channels 0, 1, 15.
    mode    = 1'b1;
    a_valid = 16'h8003;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rr_y_src", 64'(y_src), 64'(seq[k]));
    end
`endif

    // Idle: word drains, y keeps its last value.
    a_valid = '0;
    sel     = 4'd4;
    tick();
    chk("idle_y_valid", 64'(y_valid), 64'd0);
    chk("idle_y", 64'(y), RR ? 64'h0000_0000_A000_000F
                              : 64'h0000_0000_A000_0003);
    tick();
    chk("idle2_y_valid", 64'(y_valid), 64'd0);
    a_valid = 16'h0010;
    tick();
    chk("skip_y_src", 64'(y_src), 64'd4);
    chk("skip_y_valid", 64'(y_valid), 64'd1);

    // Reset while holding a stalled word.
    a_valid = '1;
    y_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("mrst_y_valid", 64'(y_valid), 64'd0);
    chk("mrst_y_src", 64'(y_src), 64'd0);
    rst     = 1'b0;
    y_ready = 1'b1;
    sel     = '0;
    tick();
    chk("mrst_ptr_src", 64'(y_src), 64'd0);

    // Random traffic against the model.
    for (int c = 0; c < 1024; c++) begin
      for (int i = 0; i < N; i++) a[i*W +: W] = $urandom;
      a_valid = (c % 3 == 0) ? N'($urandom & $urandom & $urandom)
                             : N'($urandom);
      if (c % 50 < 5) a_valid = '0;
      sel     = SW'($urandom_range(0, N - 1));
      mode    = 1'($urandom);
      y_ready = ($urandom_range(0, 3) != 0);
      rst     = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    tick();
    @(negedge clk);
    #1;
    chk_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
